rx_cmd_decoder: RTL and testbench

RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

---
 rtl/rx_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_decoder.sv
// Command decoder sitting behind a UART receiver. It assembles multi-byte
// write, read and ALU commands from the received byte stream. Once a command
// is complete it issues single-cycle strobes toward the register file or ALU.
// Handshake: a strobe (WrEn/RdEn/ALU_EN) is a valid, and !DEST_BUSY is the
// ready. A transfer happens in a cycle where both are high. While DEST_BUSY
// is high, the ISS_* state and the Address/WrData/ALU_FUN fields hold still.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  FRM_ERR,
  input  logic                  DEST_BUSY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic                  ALU_EN,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [3:0]            ALU_FUN,
  output logic                  CMD_BUSY,
  output logic                  CMD_ERR,
  output logic                  OVR_ERR,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_WADDR = 4'd1,
    GET_WDATA = 4'd2,
    GET_RADDR = 4'd3,
    GET_OPA   = 4'd4,
    GET_OPB   = 4'd5,
    GET_FUN   = 4'd6,
    ISS_WR    = 4'd7,
    ISS_RD    = 4'd8,
    ISS_ALU   = 4'd9
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  // The counter times out when it would reach TIMEOUT-1. So it fires from
  // the value one below that, and the FSM leaves the GET_* state after
  // TIMEOUT-1 idle cycles.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

  state_t                  state;
  state_t                  wr_ret;   // where ISS_WR goes after its strobe
  logic [CW-1:0]           to_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [3:0]              fun_q;
  logic                    clean;
  logic                    in_iss;

  assign clean  = RX_D_VLD && !PAR_ERR && !FRM_ERR;
  assign in_iss = (state == ISS_WR) || (state == ISS_RD) || (state == ISS_ALU);

  // Strobes are combinational so they fire in the first ISS_* cycle.
  assign WrEn      = (state == ISS_WR)  && !DEST_BUSY;
  assign RdEn      = (state == ISS_RD)  && !DEST_BUSY;
  assign ALU_EN    = (state == ISS_ALU) && !DEST_BUSY;
  assign Address   = addr_q;
  assign WrData    = data_q;
  assign ALU_FUN   = fun_q;
  assign CMD_BUSY  = (state != IDLE);
  assign dbg_state = state;

  // Command FSM, timeout counter, latched fields and the error pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      wr_ret  <= IDLE;
      to_cnt  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      fun_q   <= '0;
      CMD_ERR <= 1'b0;
      OVR_ERR <= 1'b0;
    end else begin
      CMD_ERR <= 1'b0;
      OVR_ERR <= 1'b0;
      if (state == IDLE) begin
        // An errored byte in IDLE is ignored silently.
        to_cnt <= '0;
        if (clean) begin
          if      (RX_P_DATA == CMD_WR)  state <= GET_WADDR;
          else if (RX_P_DATA == CMD_RD)  state <= GET_RADDR;
          else if (RX_P_DATA == CMD_OPS) state <= GET_OPA;
          else if (RX_P_DATA == CMD_FUN) state <= GET_FUN;
          else                           CMD_ERR <= 1'b1;
        end
      end else if (in_iss) begin
        // A byte arriving while a strobe is pending is dropped.
        if (RX_D_VLD) OVR_ERR <= 1'b1;
        if (!DEST_BUSY) state <= (state == ISS_WR) ? wr_ret : IDLE;
      end else begin
        // GET_* states: an accepted byte beats both the error abort and
        // the timeout.
        if (clean) begin
          to_cnt <= '0;
          case (state)
            GET_WADDR: begin
              addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
              state  <= GET_WDATA;
            end
            GET_WDATA: begin
              data_q <= RX_P_DATA;
              wr_ret <= IDLE;
              state  <= ISS_WR;
            end
            GET_RADDR: begin
              addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
              state  <= ISS_RD;
            end
            GET_OPA: begin
              addr_q <= '0;
              data_q <= RX_P_DATA;
              wr_ret <= GET_OPB;
              state  <= ISS_WR;
            end
            GET_OPB: begin
              addr_q <= ADDR_WIDTH'(1);
              data_q <= RX_P_DATA;
              wr_ret <= GET_FUN;
              state  <= ISS_WR;
            end
            GET_FUN: begin
              fun_q <= RX_P_DATA[3:0];
              state <= ISS_ALU;
            end
            default: state <= IDLE;
          endcase
        end else if (RX_D_VLD) begin
          to_cnt  <= '0;
          state   <= IDLE;
          CMD_ERR <= 1'b1;
        end else if (to_cnt == TO_LAST) begin
          to_cnt  <= '0;
          state   <= IDLE;
          CMD_ERR <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Bench for rx_cmd_decoder. Each expected output event is a packed record
// {cycle, kind, addr, data, fun}. The stimulus tasks push these records to
// exp_q. A negedge monitor pops and compares them as the DUT emits events.
module tb_rx_cmd_decoder;

  localparam int EW = 35;
  localparam logic [2:0] K_WR = 3'd1, K_RD = 3'd2, K_ALU = 3'd3,
                         K_CERR = 3'd4, K_OVR = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_vld = 1'b0, par_err = 1'b0, frm_err = 1'b0, dest_busy = 1'b0;
  logic       wr_en, rd_en, alu_en, cmd_busy, cmd_err, ovr_err;
  logic [3:0] address, alu_fun, dbg_state;
  logic [7:0] wr_data;

  logic [15:0]   cyc = '0;
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            passes = 0;

  rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .PAR_ERR(par_err), .FRM_ERR(frm_err), .DEST_BUSY(dest_busy),
    .WrEn(wr_en), .RdEn(rd_en), .ALU_EN(alu_en), .Address(address),
    .WrData(wr_data), .ALU_FUN(alu_fun), .CMD_BUSY(cmd_busy),
    .CMD_ERR(cmd_err), .OVR_ERR(ovr_err), .dbg_state(dbg_state)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input logic [15:0] c, input logic [2:0] k,
                                       input logic [3:0] a, input logic [7:0] d,
                                       input logic [3:0] f);
    return {c, k, a, d, f};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0]    hits;
    logic [EW-1:0] got, want;
    if (!rst) begin
      hits = {ovr_err, cmd_err, alu_en, rd_en, wr_en};
      for (int k = 0; k < 5; k++) begin
        if (hits[k]) begin
          got = ev(cyc, 3'(k + 1), (k < 2) ? address : 4'd0,
                   (k == 0) ? wr_data : 8'd0, (k == 2) ? alu_fun : 4'd0);
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d addr=%h data=%h fun=%h, need no event",
                     got[34:19], got[18:16], got[15:12], got[11:4], got[3:0]);
          end else begin
            want = exp_q.pop_front();
            if (got !== want)
              $display("FAIL event: got cyc=%0d kind=%0d addr=%h data=%h fun=%h, need cyc=%0d kind=%0d addr=%h data=%h fun=%h",
                       got[34:19], got[18:16], got[15:12], got[11:4], got[3:0],
                       want[34:19], want[18:16], want[15:12], want[11:4], want[3:0]);
            else passes++;
          end
        end
      end
    end
  end

  // driver tasks: each call leaves the bench #1 after the posedge that
  // sampled the byte, so "cyc" is the cycle in which the DUT reacts.
  task automatic send_byte(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
    @(posedge clk); #1;
    rx_data = b; rx_vld = 1'b1; par_err = pe; frm_err = fe;
    @(posedge clk); #1;
    rx_vld = 1'b0; par_err = 1'b0; frm_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    #2;
    checks++; if ({wr_en, rd_en, alu_en} !== 3'b000) $display("FAIL reset_strobes: got %b need 000", {wr_en, rd_en, alu_en}); else passes++;
    checks++; if (address !== 4'd0) $display("FAIL reset_address: got %h need 0", address); else passes++;
    checks++; if (wr_data !== 8'd0) $display("FAIL reset_wrdata: got %h need 00", wr_data); else passes++;
    checks++; if (alu_fun !== 4'd0) $display("FAIL reset_alufun: got %h need 0", alu_fun); else passes++;
    checks++; if ({cmd_busy, cmd_err, ovr_err} !== 3'b000) $display("FAIL reset_flags: got %b need 000", {cmd_busy, cmd_err, ovr_err}); else passes++;
  endtask

  task automatic test_write();
    send_byte(8'hAA);
    checks++; if (cmd_busy !== 1'b1) $display("FAIL write_busy: got %b need 1", cmd_busy); else passes++;
    send_byte(8'h05);
    send_byte(8'h3C);
    exp_q.push_back(ev(cyc, K_WR, 4'h5, 8'h3C, 4'h0));
    idle(1);
    checks++; if (cmd_busy !== 1'b0) $display("FAIL write_busy_after: got %b need 0", cmd_busy); else passes++;
    idle(3);
    checks++; if (exp_q.size() != 0) $display("FAIL write_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  task automatic test_read_busy();
    send_byte(8'hBB);
    dest_busy = 1'b1;
    send_byte(8'h07);
    // byte during the hold is dropped with an overrun pulse next cycle
    rx_data = 8'h99; rx_vld = 1'b1;
    exp_q.push_back(ev(cyc + 16'd1, K_OVR, 4'h0, 8'h00, 4'h0));
    idle(1);
    rx_vld = 1'b0;
    checks++; if (address !== 4'h7) $display("FAIL read_hold_addr: got %h need 7", address); else passes++;
    idle(2);
    dest_busy = 1'b0;
    exp_q.push_back(ev(cyc, K_RD, 4'h7, 8'h00, 4'h0));
    idle(4);
    checks++; if (exp_q.size() != 0) $display("FAIL read_drain: got %0d pending need 0", exp_q.size()); else passes++;
    checks++; if (cmd_busy !== 1'b0) $display("FAIL read_idle: got %b need 0", cmd_busy); else passes++;
  endtask

  task automatic test_alu_ops();
    send_byte(8'hCC);
    send_byte(8'h12);
    exp_q.push_back(ev(cyc, K_WR, 4'h0, 8'h12, 4'h0));
    send_byte(8'h34);
    exp_q.push_back(ev(cyc, K_WR, 4'h1, 8'h34, 4'h0));
    send_byte(8'h02);
    exp_q.push_back(ev(cyc, K_ALU, 4'h0, 8'h00, 4'h2));
    idle(4);
    checks++; if (exp_q.size() != 0) $display("FAIL alu_ops_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h55);
    exp_q.push_back(ev(cyc, K_CERR, 4'h0, 8'h00, 4'h0));
    idle(1);
    checks++; if (cmd_busy !== 1'b0) $display("FAIL bad_cmd_idle: got %b need 0", cmd_busy); else passes++;
    send_byte(8'hDD);
    send_byte(8'h0A);
    exp_q.push_back(ev(cyc, K_ALU, 4'h0, 8'h00, 4'hA));
    idle(3);
    checks++; if (exp_q.size() != 0) $display("FAIL bad_cmd_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  task automatic test_timeout();
    logic [15:0] c0;
    send_byte(8'hAA);
    c0 = cyc;
    exp_q.push_back(ev(c0 + 16'd15, K_CERR, 4'h0, 8'h00, 4'h0));
    idle(14);
    checks++; if (cmd_busy !== 1'b1) $display("FAIL timeout_still_busy: got %b need 1", cmd_busy); else passes++;
    idle(1);
    checks++; if (cmd_busy !== 1'b0) $display("FAIL timeout_idle: got %b need 0", cmd_busy); else passes++;
    idle(3);
    checks++; if (exp_q.size() != 0) $display("FAIL timeout_drain: got %0d pending need 0", exp_q.size()); else passes++;
    // a byte on the terminal-count cycle wins over the timeout
    send_byte(8'hAA);
    idle(13);
    send_byte(8'h06);
    send_byte(8'h77);
    exp_q.push_back(ev(cyc, K_WR, 4'h6, 8'h77, 4'h0));
    idle(3);
    checks++; if (exp_q.size() != 0) $display("FAIL timeout_edge_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  task automatic test_errors_reset();
    send_byte(8'hAA);
    send_byte(8'h03, 1'b1, 1'b0);
    exp_q.push_back(ev(cyc, K_CERR, 4'h0, 8'h00, 4'h0));
    idle(1);
    checks++; if (cmd_busy !== 1'b0) $display("FAIL parerr_idle: got %b need 0", cmd_busy); else passes++;
    // errored byte in IDLE is ignored with no event
    send_byte(8'hAA, 1'b0, 1'b1);
    checks++; if (cmd_busy !== 1'b0) $display("FAIL frmerr_idle_ignored: got %b need 0", cmd_busy); else passes++;
    send_byte(8'hAA);
    send_byte(8'h05);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #2;
    checks++; if ({wr_en, rd_en, alu_en, cmd_busy, cmd_err, ovr_err} !== 6'b0) $display("FAIL midreset_flags: got %b need 000000", {wr_en, rd_en, alu_en, cmd_busy, cmd_err, ovr_err}); else passes++;
    checks++; if ({address, wr_data, alu_fun} !== 16'h0000) $display("FAIL midreset_fields: got %h need 0000", {address, wr_data, alu_fun}); else passes++;
    // the would-be data byte now lands in IDLE as an unknown command
    send_byte(8'h3C);
    exp_q.push_back(ev(cyc, K_CERR, 4'h0, 8'h00, 4'h0));
    idle(3);
    checks++; if (exp_q.size() != 0) $display("FAIL errors_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      send_byte(8'hAA);
      send_byte(a);
      send_byte(d);
      exp_q.push_back(ev(cyc, K_WR, a[3:0], d, 4'h0));
      d = 8'($urandom_range(0, 255));
      send_byte(8'hDD);
      send_byte(d);
      exp_q.push_back(ev(cyc, K_ALU, 4'h0, 8'h00, d[3:0]));
    end
    idle(4);
    checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending need 0", exp_q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_busy();
    test_alu_ops();
    test_bad_cmd();
    test_timeout();
    test_errors_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
